// File: rtl/conv_encoder_framer_if.sv
// Handshake bundle between the payload source, the convolutional framer and the
// Viterbi decoder: word-in handshake on one side, 2-bit symbol stream on the other.
interface conv_encoder_framer_if #(
  parameter int FRAME_BITS = 16
) ();
  logic [2:0]            choose_constraint_length;
  logic [FRAME_BITS-1:0] data_in;
  logic                  data_valid;
  logic                  data_ready;
  logic [1:0]            encoded_bits;
  logic                  enc_valid;
  logic                  enc_ready;
  logic                  frame_start;
  logic                  frame_last;

  modport master (
    input  choose_constraint_length, data_in, data_valid, enc_ready,
    output data_ready, encoded_bits, enc_valid, frame_start, frame_last
  );

  modport slave (
    output choose_constraint_length, data_in, data_valid, enc_ready,
    input  data_ready, encoded_bits, enc_valid, frame_start, frame_last
  );
endinterface

// File: rtl/conv_encoder_framer.sv
// Rate-1/2 convolutional encoder (K=3..6) that frames one payload word MSB first
// followed by K-1 zero tail bits, so every frame ends in encoder state 0.
module conv_encoder_framer #(
  parameter int FRAME_BITS = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  conv_encoder_framer_if.master         bus
);

  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

  state_t                r_state, w_nxt_state;
  logic                  r_ready, w_nxt_ready;
  logic                  r_valid, w_nxt_valid;
  logic [1:0]            r_bits,  w_nxt_bits;
  logic                  r_start, w_nxt_start;
  logic                  r_last,  w_nxt_last;
  logic [4:0]            r_sr,    w_nxt_sr;
  logic [4:0]            r_cnt,   w_nxt_cnt;
  logic [2:0]            r_k,     w_nxt_k;
  logic [FRAME_BITS-1:0] r_data;

  logic       w_acc, w_cons;
  logic [2:0] w_kin;
  logic [4:0] w_last_idx;
  logic [4:0] w_sr_shift;

  // One symbol: generator bit K-1 taps u, bit K-2 taps s1, ... bit 0 taps s(K-1).
  // sr[0] holds s1, sr[4] holds s5.
  function automatic logic [1:0] enc_sym(input logic u, input logic [4:0] sr,
                                         input logic [2:0] k);
    logic [5:0] g0, g1, t;
    case (k)
      3'd4:    begin g0 = 6'o17; g1 = 6'o15; t = {2'b00, u, sr[0], sr[1], sr[2]}; end
      3'd5:    begin g0 = 6'o35; g1 = 6'o23; t = {1'b0, u, sr[0], sr[1], sr[2], sr[3]}; end
      3'd6:    begin g0 = 6'o75; g1 = 6'o53; t = {u, sr[0], sr[1], sr[2], sr[3], sr[4]}; end
      default: begin g0 = 6'o07; g1 = 6'o05; t = {3'b000, u, sr[0], sr[1]}; end
    endcase
    return {^(g0 & t), ^(g1 & t)};
  endfunction

  assign w_kin      = (bus.choose_constraint_length >= 3'd3 &&
                       bus.choose_constraint_length <= 3'd6) ?
                      bus.choose_constraint_length : 3'd3;
  assign w_acc      = r_ready & bus.data_valid;
  assign w_cons     = r_valid & bus.enc_ready;
  assign w_last_idx = 5'(FRAME_BITS - 2) + {2'b00, r_k};
  assign w_sr_shift = {r_sr[3:0], r_data[FRAME_BITS-1]};

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_ready = r_ready;
    w_nxt_valid = r_valid;
    w_nxt_bits  = r_bits;
    w_nxt_start = r_start;
    w_nxt_last  = r_last;
    w_nxt_sr    = r_sr;
    w_nxt_cnt   = r_cnt;
    w_nxt_k     = r_k;
    case (r_state)
      IDLE: begin
        w_nxt_ready = 1'b1;
        if (w_acc) begin
          w_nxt_state = DATA;
          w_nxt_ready = 1'b0;
          w_nxt_k     = w_kin;
          w_nxt_sr    = '0;
          w_nxt_cnt   = '0;
          w_nxt_valid = 1'b1;
          w_nxt_bits  = enc_sym(bus.data_in[FRAME_BITS-1], 5'b0, w_kin);
          w_nxt_start = 1'b1;
          w_nxt_last  = 1'b0;
        end
      end
      DATA, TAIL: begin
        if (w_cons) begin
          w_nxt_sr    = w_sr_shift;
          w_nxt_cnt   = r_cnt + 5'd1;
          w_nxt_start = 1'b0;
          if (r_cnt == w_last_idx) begin
            w_nxt_state = IDLE;
            w_nxt_valid = 1'b0;
            w_nxt_ready = 1'b1;
            w_nxt_last  = 1'b0;
            w_nxt_bits  = 2'b00;
          end else begin
            // Tail inputs come out of r_data as the zeros shifted in behind the payload.
            w_nxt_bits = enc_sym(r_data[FRAME_BITS-2], w_sr_shift, r_k);
            w_nxt_last = (r_cnt + 5'd1 == w_last_idx);
            if (r_cnt == 5'(FRAME_BITS - 1)) w_nxt_state = TAIL;
          end
        end
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
      r_bits  <= 2'b00;
      r_start <= 1'b0;
      r_last  <= 1'b0;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_k     <= 3'd3;
    end else begin
      r_state <= w_nxt_state;
      r_ready <= w_nxt_ready;
      r_valid <= w_nxt_valid;
      r_bits  <= w_nxt_bits;
      r_start <= w_nxt_start;
      r_last  <= w_nxt_last;
      r_sr    <= w_nxt_sr;
      r_cnt   <= w_nxt_cnt;
      r_k     <= w_nxt_k;
    end
  end

  // Payload shifter is pure data; the control path alone decides when it is meaningful.
  always_ff @(posedge clk) begin
    if (w_acc)       r_data <= bus.data_in;
    else if (w_cons) r_data <= {r_data[FRAME_BITS-2:0], 1'b0};
  end

  assign bus.data_ready   = r_ready;
  assign bus.enc_valid    = r_valid;
  assign bus.encoded_bits = r_bits;
  assign bus.frame_start  = r_start;
  assign bus.frame_last   = r_last;

endmodule

// File: doc/conv_encoder_framer.md
CONV_ENCODER_FRAMER -- requirements
Module: conv_encoder_framer

Interface
REQ-001 SHALL provide parameter FRAME_BITS, default 16, payload bits per frame; matches the decoder's 16-bit final_output.
REQ-002 SHALL provide port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL provide port choose_constraint_length, input, 3 bits, constraint length K; 3..6 valid.
REQ-005 SHALL provide port data_in, input, FRAME_BITS bits, payload word.
REQ-006 SHALL provide port data_valid, input, 1 bit, data_in is valid.
REQ-007 SHALL provide port data_ready, output, 1 bit, encoder can accept a word.
REQ-008 SHALL provide port encoded_bits, output, 2 bits; [1] = g0 output, [0] = g1 output; feeds the Viterbi decoder.
REQ-009 SHALL provide port enc_valid, output, 1 bit, encoded_bits is valid.
REQ-010 SHALL provide port enc_ready, input, 1 bit, downstream accepts the symbol.
REQ-011 SHALL provide port frame_start, output, 1 bit, high with the first symbol of a frame.
REQ-012 SHALL provide port frame_last, output, 1 bit, high with the final tail symbol.

Function
REQ-013 SHALL implement FSM states IDLE, DATA, TAIL.
REQ-014 In IDLE, data_ready SHALL be 1; in DATA and TAIL it SHALL be 0; all outputs are registered.
REQ-015 A word SHALL be accepted on an edge where data_valid && data_ready; transition IDLE->DATA.
REQ-016 On acceptance, data_in, K and a zeroed shift register (s1..s5) SHALL be latched.
REQ-017 K SHALL be latched only at acceptance; choose_constraint_length changes mid-frame are ignored.
REQ-018 choose_constraint_length values 0, 1, 2 and 7 SHALL be treated as K=3.
REQ-019 Generators (octal, g0/g1) SHALL be: K=3 7/5; K=4 17/15; K=5 35/23; K=6 75/53.
REQ-020 Generator bit K-1 SHALL tap current input u, bit K-2 tap s1, ..., bit 0 tap s(K-1).
REQ-021 Each output bit SHALL be the XOR over the tapped bits.
REQ-022 In DATA, payload bits SHALL be encoded MSB first, one per symbol handshake.
REQ-023 In TAIL, K-1 zero input bits SHALL be encoded, returning the encoder to state 0.
REQ-024 A frame SHALL be exactly FRAME_BITS+K-1 symbols: 18 for K=3, 21 for K=6.
REQ-025 The first symbol SHALL present enc_valid=1 on the edge after acceptance (latency 1 cycle).
REQ-026 A symbol SHALL be consumed on an edge with enc_valid && enc_ready.
REQ-027 On consumption, shift s1<=u, si<=s(i-1) and advance the symbol counter.
REQ-028 While enc_valid && !enc_ready, encoded_bits, frame_start and frame_last SHALL hold stable.
REQ-029 enc_valid SHALL stay 1 for every symbol of the frame; no bubbles unless the downstream stalls.
REQ-030 DATA->TAIL SHALL occur on consumption of payload bit 0.
REQ-031 TAIL->IDLE SHALL occur on consumption of the frame_last symbol; that edge SHALL drive enc_valid=0 and data_ready=1.
REQ-032 The symbol counter SHALL be 5 bits, with no wrap within a frame, and SHALL be cleared on acceptance.
REQ-033 frame_start and frame_last SHALL never both be 1.
REQ-034 data_valid outside IDLE SHALL be ignored; data_in is not sampled.

Reset
REQ-035 While rst_n=0, the block SHALL hold: state=IDLE, data_ready=0, enc_valid=0, encoded_bits=00, frame_start=0, frame_last=0, shift register=0, counter=0.
REQ-036 data_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-037 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously); no residual symbols after release.

Verification
REQ-038 Impulse, K=3, data_in=16'h8000, enc_ready=1 -> 18 symbols 11,10,11 then 15x00; frame_start on symbol 1, frame_last on symbol 18.
REQ-039 Impulse, K=4, data_in=16'h8000 -> 19 symbols 11,11,10,11 then 15x00; all-zero word at K=6 -> 21x00.
REQ-040 Backpressure, K=3, 16'h8000, enc_ready low 3 cycles while symbol 2 (10) is shown -> 10 held 4 cycles; sequence unchanged.
REQ-041 K change mid-frame: accept at K=3, switch input to 6 at symbol 5 -> frame still 18 symbols with K=3 values; next frame uses K=6 (21 symbols).
REQ-042 Reset mid-frame: rst_n low at symbol 7 -> enc_valid=0 immediately; data_ready=1 one edge after release; next frame 16'h8000 again yields 11,10,11,...
REQ-043 Encode random words at K=3..6 through the Viterbi decoder, error-free -> decoded word equals data_in.
